// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared definitions for the round-robin adder arbiter.
//   - FSM state encoding (IDLE / ADD / RESP)
//   - default requester count and operand width
//   - width of the optional settle down-counter (build with ADD_ARB_SETTLE_EN)
package adder_arb_pkg;

  localparam int ADD_ARB_N_DEF = 4;
  localparam int ADD_ARB_W_DEF = 5;
  localparam int SETTLE_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/adder_arbiter_ripple_add.sv
// ripple_add: W-bit ripple-carry adder built from a chain of full-adder cells.
// Ports:
//   a, b  [W-1:0]  operands
//   cin            carry into bit 0
//   sum   [W-1:0]  a + b + cin, modulo 2^W
//   cout           carry out of bit W-1
module ripple_add
  import adder_arb_pkg::*;
#(
  parameter int W = ADD_ARB_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one ripple_add among N requesters.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/ready [N]   per-requester operand handshake (ready is one-hot)
//   req_x, req_y [N*W]    operands, requester i in bits [i*W +: W]
//   rsp_valid [N]         one-hot registered result valid to the granted requester
//   rsp_sum [W], rsp_cout registered result, {cout,sum} = X + Y
//   rsp_ready [N]         result accept, only the granted bit is looked at
// Build option: define ADD_ARB_SETTLE_EN to stretch ADD to SETTLE_CYC cycles
// using a down-counter; otherwise ADD lasts one cycle and SETTLE_CYC is ignored.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N          = ADD_ARB_N_DEF,
  parameter int W          = ADD_ARB_W_DEF,
  parameter int SETTLE_CYC = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_cout,
  input  logic [N-1:0]   rsp_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] grant_q;
  logic [W-1:0]  op_x_q;
  logic [W-1:0]  op_y_q;
  logic [N-1:0]  rsp_valid_q;
  logic [W-1:0]  rsp_sum_q;
  logic          rsp_cout_q;

  logic          sel_any;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] ptr_next;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          add_last;

  // First valid requester at or after ptr, wrapping modulo N. Scanning from
  // the far end down lets the closest candidate overwrite earlier hits.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0]  valid,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (valid[idx]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    {sel_any, sel_idx} = rr_pick(req_valid, ptr_q);
  end

  assign ptr_next = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + PW'(1);

  ripple_add #(.W(W)) u_add (
    .a    (op_x_q),
    .b    (op_y_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADD_ARB_SETTLE_EN
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);

  logic [SETTLE_CNT_W-1:0] settle_cnt_q;

  // Loaded on the grant edge so the first ADD cycle already sees the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_q <= '0;
    end else if (state_q == IDLE && sel_any) begin
      settle_cnt_q <= SETTLE_LOAD;
    end else if (state_q == ADD && settle_cnt_q != '0) begin
      settle_cnt_q <= settle_cnt_q - 1'b1;
    end
  end

  assign add_last = (settle_cnt_q == '0);
`else
  // SETTLE_CYC has no effect in this build.
  if (SETTLE_CYC < 0) begin : g_settle_unused
  end

  assign add_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_any) state_d = ADD;
      ADD:     if (add_last) state_d = RESP;
      RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: accept strobe only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && sel_any && !rst) req_ready[sel_idx] = 1'b1;
  end

  // Operand capture, grant/pointer update and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_any) begin
            op_x_q  <= req_x[int'(sel_idx)*W +: W];
            op_y_q  <= req_y[int'(sel_idx)*W +: W];
            grant_q <= sel_idx;
            ptr_q   <= ptr_next;
          end
        end
        ADD: begin
          if (add_last) begin
            rsp_sum_q   <= add_sum;
            rsp_cout_q  <= add_cout;
            rsp_valid_q <= N'(1) << grant_q;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) rsp_valid_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int N          = 4;
  localparam int W          = 5;
  localparam int SETTLE_CYC = 3;
`ifdef ADD_ARB_SETTLE_EN
  localparam int LAT = 1 + SETTLE_CYC;
`else
  localparam int LAT = 2;
`endif
  localparam int P = LAT + 1;  // grant-to-grant period with rsp_ready held high

  typedef struct packed {
    int           idx;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [N-1:0]   rsp_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  adder_arbiter #(.N(N), .W(W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = 1;
    return v << idx;
  endfunction

  // Bounded wait for any accept, then require it to be the given requester.
  task automatic expect_grant(input int idx, input int sum, input int cout, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready == '0 && n < 60) begin
      tick();
      #1;
      n++;
    end
    chk($sformatf("grant_req%0d", idx), 32'(req_ready), 32'(onehot(idx)));
    if (push) begin
      e.idx  = idx;
      e.sum  = W'(sum);
      e.cout = cout[0];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic go(input int idx, input int x, input int y, input int sum, input int cout);
    req_x[idx*W +: W] = W'(x);
    req_y[idx*W +: W] = W'(y);
    req_valid[idx]    = 1'b1;
    #1;
    expect_grant(idx, sum, cout, 1'b1);
    tick();
    req_valid[idx] = 1'b0;
    wait_drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Response monitor: compares whenever a result is accepted by its requester.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!$onehot0(rsp_valid)) chk("rsp_valid_onehot", 32'(rsp_valid), 32'(0));
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b expected no response", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(onehot(e.idx)));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        end
      end
    end
  end

  initial begin
    int           n;
    logic [N-1:0] exp_rdy;

    rst       = 1'b1;
    req_valid = 4'b0001;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = '1;
    tick();
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_rsp_sum", 32'(rsp_sum), 32'(0));
    chk("reset_rsp_cout", 32'(rsp_cout), 32'(0));
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Single request with cycle-accurate latency.
    req_x[0*W +: W] = 5'd13;
    req_y[0*W +: W] = 5'd9;
    req_valid       = 4'b0001;
    #1;
    expect_grant(0, 22, 0, 1'b1);
    tick();
    req_valid = '0;
    for (int c = 1; c < LAT; c++) begin
      chk("single_rsp_valid_add", 32'(rsp_valid), 32'(0));
      tick();
    end
    chk("single_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    chk("single_rsp_sum", 32'(rsp_sum), 32'(22));
    tick();
    chk("single_back_idle", 32'(rsp_valid), 32'(0));
    tick();

    // Overflow on requester 2.
    go(2, 31, 1, 0, 1);
    go(2, 20, 15, 3, 1);

    // Fairness: all requesters held valid from ptr=0.
    do_reset();
    req_x     = {5'd10, 5'd30, 5'd16, 5'd3};
    req_y     = {5'd11, 5'd5, 5'd16, 5'd4};
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    for (int c = 0; c <= 4 * P; c++) begin
      exp_rdy = (c % P == 0) ? onehot((c / P) % N) : '0;
      chk($sformatf("fair_req_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
      if (c % P == 0) begin
        case ((c / P) % N)
          0: exp_q.push_back('{0, 5'd7, 1'b0});
          1: exp_q.push_back('{1, 5'd0, 1'b1});
          2: exp_q.push_back('{2, 5'd3, 1'b1});
          default: exp_q.push_back('{3, 5'd21, 1'b0});
        endcase
      end
      tick();
      #1;
    end
    req_valid = '0;
    wait_drain();

    // Backpressure: requester 1 held in RESP, rsp_ready[0] must be ignored.
    req_x[1*W +: W] = 5'd11;
    req_y[1*W +: W] = 5'd6;
    req_valid       = 4'b0010;
    rsp_ready       = 4'b0001;
    #1;
    expect_grant(1, 17, 0, 1'b1);
    tick();
    req_valid = '0;
    for (int c = 1; c < LAT; c++) tick();
    req_x[0*W +: W] = 5'd25;
    req_y[0*W +: W] = 5'd4;
    req_valid       = 4'b0001;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
      chk("bp_rsp_sum", 32'(rsp_sum), 32'(17));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      tick();
      #1;
    end
    rsp_ready = 4'b0010;
    expect_grant(0, 29, 0, 1'b1);
    rsp_ready = 4'b1111;
    tick();
    req_valid = '0;
    wait_drain();

    // Reset during ADD: transaction dropped, pointer back to 0.
    req_x[1*W +: W] = 5'd9;
    req_y[1*W +: W] = 5'd10;
    req_valid       = 4'b0010;
    #1;
    expect_grant(1, 19, 0, 1'b0);
    tick();
    req_x[2*W +: W] = 5'd12;
    req_y[2*W +: W] = 5'd12;
    req_valid       = 4'b0110;
    rst             = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    tick();
    rst = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_sum", 32'(rsp_sum), 32'(0));
    chk("rst_rsp_cout", 32'(rsp_cout), 32'(0));
    #1;
    expect_grant(1, 19, 0, 1'b1);
    tick();
    req_valid = 4'b0100;
    #1;
    expect_grant(2, 24, 0, 1'b1);
    tick();
    req_valid = '0;
    wait_drain();

    // Latency measurement (one-cycle or stretched ADD).
    req_x[3*W +: W] = 5'd7;
    req_y[3*W +: W] = 5'd8;
    req_valid       = 4'b1000;
    #1;
    expect_grant(3, 15, 0, 1'b1);
    tick();
    req_valid = '0;
    n = 1;
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
